// File: rtl/vproc_irq_ctrl.sv
// vproc_irq_ctrl
// Memory-mapped interrupt controller sitting in front of one VProc Interrupt
// bit. Sources are captured in edge or level mode, masked, and combined into
// a single registered irq. VProc reads and writes the control registers over
// its Addr/WE/RD bus, decoded in one 256MB segment selected by addr[31:28].
//
// Bus handshake: a strobe (we or rd) is held by VProc until the matching ack
// is seen. The ack is registered and pulses for exactly one cycle, starting
// the cycle after the strobe is first sampled with cs high. A strobe still
// held on the ack cycle is ignored, so each access completes exactly once.
// When we and rd are both high, only the write is performed. rdata is loaded
// on the edge that raises rdack and holds until the next read.
//
// Register map (word offset = addr[4:2]):
//   0 STATUS  RO  pending
//   1 MASK    RW  1 = source enabled
//   2 CLEAR   WO  write 1 to clear an edge-mode pending bit
//   3 MODE    RW  1 = edge, 0 = level
//   4 VECTOR  RO  {valid, 26'b0, lowest enabled pending index}
//   5..7      read 0, writes ignored but acknowledged
module vproc_irq_ctrl #(
  parameter int          NUM_SRC  = 8,
  parameter logic [3:0]  BASE_SEG = 4'hc
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [31:0]        addr,
  input  logic               we,
  input  logic               rd,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               wrack,
  output logic               rdack,
  output logic               irq
);

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_CLEAR  = 3'd2;
  localparam logic [2:0] OFF_MODE   = 3'd3;
  localparam logic [2:0] OFF_VECTOR = 3'd4;

  // State
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mode;

  // Decode
  logic               cs;
  logic [2:0]         offset;
  logic               wr_en;
  logic               rd_en;
  logic               mask_we;
  logic               mode_we;
  logic [NUM_SRC-1:0] clr_bits;

  // Derived
  logic [NUM_SRC-1:0] edge_set;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] active;
  logic               vec_valid;
  logic [4:0]         vec_idx;
  logic [31:0]        rdata_nxt;

  // Address bits outside the segment and word offset, and write data above
  // NUM_SRC, carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{addr[27:5], addr[1:0], wdata[31:NUM_SRC]};

  assign cs     = (addr[31:28] == BASE_SEG);
  assign offset = addr[4:2];

  // An access is accepted only on the cycle its ack is not already high.
  assign wr_en = we & cs & ~wrack;
  assign rd_en = rd & ~we & cs & ~rdack;

  assign mask_we  = wr_en & (offset == OFF_MASK);
  assign mode_we  = wr_en & (offset == OFF_MODE);
  assign clr_bits = (wr_en && offset == OFF_CLEAR) ? wdata[NUM_SRC-1:0]
                                                   : '0;

  // Next pending: edge bits latch rising edges (set beats clear), level bits
  // track the source directly and ignore CLEAR.
  always_comb begin
    edge_set    = src & ~src_d;
    pending_nxt = (mode & ((pending & ~clr_bits) | edge_set)) | (~mode & src);
  end

  // Lowest-index enabled pending source; scanned high to low so the lowest wins.
  always_comb begin
    active    = pending & mask;
    vec_valid = 1'b0;
    vec_idx   = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_valid = 1'b1;
        vec_idx   = 5'(i);
      end
    end
  end

  // Read data mux; unused offsets and bits above NUM_SRC read as zero.
  always_comb begin
    rdata_nxt = 32'd0;
    case (offset)
      OFF_STATUS: rdata_nxt = {{(32-NUM_SRC){1'b0}}, pending};
      OFF_MASK:   rdata_nxt = {{(32-NUM_SRC){1'b0}}, mask};
      OFF_MODE:   rdata_nxt = {{(32-NUM_SRC){1'b0}}, mode};
      OFF_VECTOR: rdata_nxt = {vec_valid, 26'd0, vec_idx};
      default:    rdata_nxt = 32'd0;
    endcase
  end

  // Source capture, pending and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_d   <= '0;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      src_d   <= src;
      pending <= pending_nxt;
      if (mask_we) mask <= wdata[NUM_SRC-1:0];
      if (mode_we) mode <= wdata[NUM_SRC-1:0];
    end
  end

  // Bus acknowledges and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrack <= 1'b0;
      rdack <= 1'b0;
      rdata <= 32'd0;
    end else begin
      wrack <= wr_en;
      rdack <= rd_en;
      if (rd_en) rdata <= rdata_nxt;
    end
  end

  // Registered interrupt request from the enabled pending set.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(pending & mask);
  end

endmodule

// File: tb/tb_vproc_irq_ctrl.sv
// Directed bench for vproc_irq_ctrl. Reads push their expected data into a
// queue; a negedge monitor pops and compares whenever rdack is seen.
module tb_vproc_irq_ctrl;

  localparam int NUM_SRC = 8;

  localparam logic [31:0] A_STATUS = 32'hc000_0000;
  localparam logic [31:0] A_MASK   = 32'hc000_0004;
  localparam logic [31:0] A_CLEAR  = 32'hc000_0008;
  localparam logic [31:0] A_MODE   = 32'hc000_000c;
  localparam logic [31:0] A_VECTOR = 32'hc000_0010;

  logic               clk;
  logic               reset;
  logic [NUM_SRC-1:0] src;
  logic [31:0]        addr;
  logic               we;
  logic               rd;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               wrack;
  logic               rdack;
  logic               irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic        rdack_prev = 1'b0;

  vproc_irq_ctrl #(.NUM_SRC(NUM_SRC), .BASE_SEG(4'hc)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .addr  (addr),
    .we    (we),
    .rd    (rd),
    .wdata (wdata),
    .rdata (rdata),
    .wrack (wrack),
    .rdack (rdack),
    .irq   (irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare read data against the scoreboard on every rdack.
  always @(negedge clk) begin
    if (rdack) begin
      check("rdack_single_pulse", {31'd0, rdack_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdack: rdack=1 with no read issued, required 0");
      end else begin
        logic [31:0] e;
        logic [31:0] a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        checks++;
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata@%08h: actual 0x%08h required 0x%08h", a, rdata, e);
        end
      end
    end
    rdack_prev = rdack;
  end

  // Driver tasks
  task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
    int n;
    logic got;
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(posedge clk); #1;
    addr = a;
    rd   = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      if (rdack) got = 1'b1;
    end
    check("rdack_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic bus_write_x(input logic [31:0] a, input logic [31:0] d,
                             input logic [NUM_SRC-1:0] s, input logic r,
                             output logic irq_at_ack);
    int n;
    logic got;
    @(posedge clk); #1;
    addr  = a;
    wdata = d;
    src   = s;
    we    = 1'b1;
    rd    = r;
    n = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      if (wrack) got = 1'b1;
    end
    check("wrack_latency", 32'(n), 32'd2);
    irq_at_ack = irq;
    @(posedge clk); #1;
    we = 1'b0;
    rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           output logic irq_at_ack);
    bus_write_x(a, d, src, 1'b0, irq_at_ack);
  endtask

  task automatic pulse_src(input logic [NUM_SRC-1:0] s);
    @(posedge clk); #1 src = s;
    @(posedge clk); #1 src = '0;
  endtask

  // Stimulus
  initial begin
    logic ia;
    logic ack_seen;
    reset = 1'b1;
    src   = '0;
    addr  = '0;
    we    = 1'b0;
    rd    = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_irq",   {31'd0, irq},   32'd0);
    check("reset_wrack", {31'd0, wrack}, 32'd0);
    check("reset_rdack", {31'd0, rdack}, 32'd0);
    check("reset_rdata", rdata,          32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset values of all readable registers
    bus_read(A_STATUS, 32'h0);
    bus_read(A_MASK,   32'h0);
    bus_read(A_CLEAR,  32'h0);
    bus_read(A_MODE,   32'h0);
    bus_read(A_VECTOR, 32'h0);

    // Edge mode, enabled source: irq two cycles after the source edge
    bus_write(A_MODE, 32'hff, ia);
    bus_write(A_MASK, 32'h05, ia);
    pulse_src(8'h04);
    check("edge_irq_after_1", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("edge_irq_after_2", {31'd0, irq}, 32'd1);
    bus_read(A_STATUS, 32'h04);
    bus_read(A_VECTOR, 32'h8000_0002);
    bus_write(A_CLEAR, 32'h04, ia);
    check("clear_irq_at_wrack", {31'd0, ia},  32'd1);
    check("clear_irq_after",    {31'd0, irq}, 32'd0);
    bus_read(A_STATUS, 32'h00);

    // Masked source stays pending without irq until enabled
    bus_write(A_MASK, 32'h00, ia);
    pulse_src(8'h01);
    repeat (2) @(posedge clk);
    #1;
    check("masked_irq", {31'd0, irq}, 32'd0);
    bus_read(A_STATUS, 32'h01);
    bus_read(A_VECTOR, 32'h0);
    bus_write(A_MASK, 32'h01, ia);
    check("unmask_irq_at_wrack", {31'd0, ia},  32'd0);
    check("unmask_irq_after",    {31'd0, irq}, 32'd1);
    bus_read(A_VECTOR, 32'h8000_0000);
    bus_write(A_CLEAR, 32'h01, ia);
    check("clear0_irq_after", {31'd0, irq}, 32'd0);

    // Clear and rising edge on the same clock: set wins
    bus_write_x(A_CLEAR, 32'h08, 8'h08, 1'b0, ia);
    @(posedge clk); #1 src = '0;
    bus_read(A_STATUS, 32'h08);
    bus_write(A_CLEAR, 32'h08, ia);
    bus_read(A_STATUS, 32'h00);

    // Level mode: pending follows src, CLEAR has no effect
    bus_write(A_MODE, 32'h00, ia);
    bus_write(A_MASK, 32'h02, ia);
    @(posedge clk); #1 src = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    check("level_irq_high", {31'd0, irq}, 32'd1);
    bus_read(A_STATUS, 32'h02);
    bus_write(A_CLEAR, 32'h02, ia);
    bus_read(A_STATUS, 32'h02);
    @(posedge clk); #1 src = '0;
    @(posedge clk); #1;
    check("level_drop_irq_1", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    check("level_drop_irq_2", {31'd0, irq}, 32'd0);
    bus_read(A_STATUS, 32'h00);

    // Unused offsets and bits above NUM_SRC
    bus_write(32'hc000_0018, 32'hffff_ffff, ia);
    bus_read(32'hc000_0014, 32'h0);
    bus_read(32'hc000_0018, 32'h0);
    bus_write(A_MASK, 32'hffff_ff0f, ia);
    bus_read(A_MASK, 32'h0f);

    // Accesses outside the segment: no ack, no state change
    ack_seen = 1'b0;
    @(posedge clk); #1;
    addr = 32'ha000_0000;
    rd   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rdack || wrack) ack_seen = 1'b1;
    end
    @(posedge clk); #1;
    rd    = 1'b0;
    addr  = 32'ha000_0004;
    wdata = 32'h0;
    we    = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rdack || wrack) ack_seen = 1'b1;
    end
    @(posedge clk); #1 we = 1'b0;
    check("out_of_segment_ack", {31'd0, ack_seen}, 32'd0);
    bus_read(A_MASK, 32'h0f);

    // we and rd together: write only
    bus_write_x(A_MASK, 32'h3, src, 1'b1, ia);
    bus_read(A_MASK, 32'h3);

    // Reset during a held read: no ack under reset, re-acked afterwards
    exp_q.push_back(32'h0);
    addr_q.push_back(A_MASK);
    @(posedge clk); #1;
    reset = 1'b1;
    addr  = A_MASK;
    rd    = 1'b1;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rdack || wrack) ack_seen = 1'b1;
    end
    check("ack_under_reset", {31'd0, ack_seen}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    ack_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rdack) ack_seen = 1'b1;
    end
    check("reack_after_reset", {31'd0, ack_seen}, 32'd1);
    @(posedge clk); #1 rd = 1'b0;
    bus_read(A_MODE, 32'h0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vproc_irq_ctrl.md
Name: vproc_irq_ctrl

Overview:
- Memory-mapped interrupt controller directly upstream of a VProc node's Interrupt input.
- Collects NUM_SRC interrupt sources, latches them in edge or level mode, and masks them. Drives a single registered interrupt request into VProc.
- The VProc node reads, masks and clears sources over its own Addr/WE/RD/DataOut/DataIn/WRAck/RDAck bus, decoded in one 256MB address segment.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..31.
- BASE_SEG, 4'hc, value of addr[31:28] that selects this block.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- src  input  NUM_SRC  interrupt sources, synchronous to clk.
- addr  input  32  VProc Addr.
- we  input  1  VProc WE, held until wrack.
- rd  input  1  VProc RD, held until rdack.
- wdata  input  32  VProc DataOut.
- rdata  output  32  to VProc DataIn; valid while rdack high.
- wrack  output  1  write acknowledge, to VProc WRAck.
- rdack  output  1  read acknowledge, to VProc RDAck.
- irq  output  1  interrupt request, to one VProc Interrupt bit.

Behaviour:
- Decode: cs = (addr[31:28]==BASE_SEG). Register offset is addr[4:2].
- Register map:
  - 0 STATUS (RO): pending[NUM_SRC-1:0].
  - 1 MASK (RW): 1 = enabled.
  - 2 CLEAR (WO, write-1-to-clear pending).
  - 3 MODE (RW): 1 = edge, 0 = level.
  - 4 VECTOR (RO): bit31 = valid, [4:0] = lowest-index pending&MASK bit; all zero if none.
  - 5..7: read 0, writes ignored, still acked.
- Register bits at and above NUM_SRC read 0 and ignore writes.
- Handshake: wrack <= we & cs & ~wrack; rdack <= rd & ~we & cs & ~rdack.
  - Ack is asserted the cycle after the strobe is first sampled, and pulses for exactly one cycle per access even if the strobe is held one extra cycle.
  - A write takes effect on the same edge that asserts wrack, exactly once.
  - rdata is registered on the edge that asserts rdack. It holds that value until the next read; it is 0 after reset.
- we and rd both high: write only; no rdack.
- Access outside the segment: no ack, no state change.
- Source capture: src_d <= src every cycle.
  - Edge-mode bit: pending set on src & ~src_d; cleared by CLEAR write of 1. Simultaneous set and clear: set wins.
  - Level-mode bit: pending <= src (registered copy); CLEAR has no effect.
  - Changing MODE from edge to level: pending follows src from the next cycle.
  - Changing MODE from level to edge: pending holds its current value until cleared.
- irq <= |(pending & MASK). Latency from src rising (edge mode, unmasked) to irq high is 2 cycles: pending at edge 1, irq at edge 2. MASK write to irq change is 1 cycle after the write edge.
- Reset values: pending, MASK, MODE, src_d all 0. Outputs irq, wrack, rdack, rdata all 0.
- Reset asserted mid-access: acks drop next edge, no register update. The held strobe is re-acked after reset deasserts.

Test Plan:
- Reset, then read offsets 0..4 at 0xc0000000..0xc0000010 -> all read 0. Each rdack is a single-cycle pulse one cycle after rd.
- MODE=0xFF, MASK=0x05, pulse src[2] for 1 cycle -> STATUS=0x04, irq high 2 cycles after the src edge. VECTOR=0x80000002. Write CLEAR=0x04 -> irq low the cycle after wrack.
- MASK=0x00, src[0] edge -> STATUS=0x01, irq stays 0. Write MASK=0x01 -> irq=1 one cycle after wrack.
- Edge mode, CLEAR=0x08 written on the same edge as a src[3] rising edge -> STATUS still 0x08.
- Level mode, src[1] held high -> STATUS=0x02 and CLEAR=0x02 has no effect. Drop src[1] -> STATUS=0 and irq=0 one cycle later.
- Read at 0xa0000000, and we+rd together at 0xc0000004 with wdata 0x3 -> no ack for the first access. For the second, wrack only, MASK=0x3.
